// File: rtl/gpu_wb_pkg.sv
// Shared types and widths for the GPU writeback stage.
// The datapath widths mirror the global GPU definitions (opcode, scalar
// register, vector register and vector register id widths).
package gpu_wb_pkg;

  localparam int unsigned OPCODE_WIDTH  = 8;
  localparam int unsigned REG_WIDTH     = 16;
  localparam int unsigned VREG_WIDTH    = 64;
  localparam int unsigned VREG_ID_WIDTH = 6;

  localparam int unsigned WB_LANES       = 4;
  localparam int unsigned WB_LANE_WIDTH  = 16;
  localparam int unsigned WB_LANE_IDX_W  = $clog2(WB_LANES);

  typedef enum logic {
    WB_IDLE   = 1'b0,
    WB_VWRITE = 1'b1
  } wb_state_t;

endpackage : gpu_wb_pkg

// File: rtl/vreg_lane_serializer.sv
// Serialises one vector register write into LANES single-lane writes.
// Holds the vector in a register, walks a lane counter and raises stall_o
// for the duration of the lanes that follow lane 0. Updates on negedge clk_i.
// LANES must be at least 2.
//   clk_i, rst_i       : clock (negedge), synchronous active-high reset
//   start_i            : accepted vector write this edge
//   vec_i, vidx_i      : vector value and destination register id
//   stall_o            : upstream hold while lanes 1..LANES-1 drain
//   vwen_o, vidx_o, lane_idx_o, lane_val_o : VRF lane write port
module vreg_lane_serializer
  import gpu_wb_pkg::*;
#(
  parameter int unsigned LANES      = WB_LANES,
  parameter int unsigned LANE_WIDTH = WB_LANE_WIDTH,
  parameter int unsigned VID_W      = VREG_ID_WIDTH,
  localparam int unsigned LANE_IDX_W = $clog2(LANES)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic [LANES*LANE_WIDTH-1:0] vec_i,
  input  logic [VID_W-1:0]            vidx_i,
  output logic                        stall_o,
  output logic                        vwen_o,
  output logic [VID_W-1:0]            vidx_o,
  output logic [LANE_IDX_W-1:0]       lane_idx_o,
  output logic [LANE_WIDTH-1:0]       lane_val_o
);

  localparam logic [LANE_IDX_W-1:0] LAST_LANE = LANE_IDX_W'(LANES - 1);

  wb_state_t                              state_q, state_d;
  logic [LANES-1:0][LANE_WIDTH-1:0]       hold_q, hold_d;
  logic [LANE_IDX_W-1:0]                  lane_cnt_q, lane_cnt_d;
  logic                                   stall_q, stall_d;
  logic                                   vwen_q, vwen_d;
  logic [VID_W-1:0]                       vidx_q, vidx_d;
  logic [LANE_IDX_W-1:0]                  lane_idx_q, lane_idx_d;
  logic [LANE_WIDTH-1:0]                  lane_val_q, lane_val_d;

  // Next-state and lane-port logic; lane 0 goes out on the accept edge itself.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    lane_cnt_d = lane_cnt_q;
    stall_d    = stall_q;
    vwen_d     = 1'b0;
    vidx_d     = vidx_q;
    lane_idx_d = lane_idx_q;
    lane_val_d = lane_val_q;
    unique case (state_q)
      WB_IDLE: begin
        if (start_i) begin
          hold_d     = vec_i;
          vidx_d     = vidx_i;
          vwen_d     = 1'b1;
          lane_idx_d = '0;
          lane_val_d = vec_i[LANE_WIDTH-1:0];
          lane_cnt_d = LANE_IDX_W'(1);
          stall_d    = 1'b1;
          state_d    = WB_VWRITE;
        end
      end
      WB_VWRITE: begin
        vwen_d     = 1'b1;
        lane_idx_d = lane_cnt_q;
        lane_val_d = hold_q[lane_cnt_q];
        if (lane_cnt_q == LAST_LANE) begin
          // Stall drops with the last lane so upstream can issue next edge.
          lane_cnt_d = '0;
          stall_d    = 1'b0;
          state_d    = WB_IDLE;
        end else begin
          lane_cnt_d = lane_cnt_q + LANE_IDX_W'(1);
        end
      end
      default: state_d = WB_IDLE;
    endcase
  end

  // State register; reset aborts any in-flight vector write.
  always_ff @(negedge clk_i) begin
    if (rst_i) begin
      state_q    <= WB_IDLE;
      hold_q     <= '0;
      lane_cnt_q <= '0;
      stall_q    <= 1'b0;
      vwen_q     <= 1'b0;
      vidx_q     <= '0;
      lane_idx_q <= '0;
      lane_val_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      lane_cnt_q <= lane_cnt_d;
      stall_q    <= stall_d;
      vwen_q     <= vwen_d;
      vidx_q     <= vidx_d;
      lane_idx_q <= lane_idx_d;
      lane_val_q <= lane_val_d;
    end
  end

  assign stall_o    = stall_q;
  assign vwen_o     = vwen_q;
  assign vidx_o     = vidx_q;
  assign lane_idx_o = lane_idx_q;
  assign lane_val_o = lane_val_q;

endmodule : vreg_lane_serializer

// File: rtl/writeback_stage.sv
// GPU writeback stage: commits scalar, condition-code and vector register
// writes from the memory stage and counts retired instructions. Vector
// writes are serialised lane by lane by vreg_lane_serializer, which also
// produces the upstream stall. All state updates on negedge I_CLOCK.
// Optional macro WB_BYPASS_EN: drives the combinational decode bypass
// (O_Fwd*); otherwise those ports are tied to 0.
// Ports:
//   I_CLOCK, I_RESET            : clock, synchronous active-high reset
//   I_LOCK, I_MEM_Valid         : pipeline running / instruction valid
//   I_Opcode                    : opcode (not used for commit)
//   I_DestRegIdx/Value, I_RegWEn: scalar result
//   I_CCValue, I_CCWEn          : condition codes
//   I_DestVRegIdx, I_VecDestValue, I_VRegWEn : vector result
//   O_WBStall                   : hold memory stage
//   O_RegWEn/O_DestRegIdx/O_DestValue       : scalar RF write port
//   O_CCWEn/O_CCValue                       : CC write port
//   O_VRegWEn/O_DestVRegIdx/O_VRegLaneIdx/O_VRegLaneValue : VRF lane port
//   O_RetireCount                : retired-instruction count
//   O_FwdValid/O_FwdRegIdx/O_FwdValue       : decode bypass
module writeback_stage
  import gpu_wb_pkg::*;
#(
  parameter int unsigned LANES            = WB_LANES,
  parameter int unsigned LANE_WIDTH       = WB_LANE_WIDTH,
  parameter int unsigned RETIRE_CNT_WIDTH = 16,
  localparam int unsigned LANE_IDX_W      = $clog2(LANES)
) (
  input  logic                        I_CLOCK,
  input  logic                        I_RESET,
  input  logic                        I_LOCK,
  input  logic                        I_MEM_Valid,
  input  logic [OPCODE_WIDTH-1:0]     I_Opcode,
  input  logic [3:0]                  I_DestRegIdx,
  input  logic [REG_WIDTH-1:0]        I_DestValue,
  input  logic                        I_RegWEn,
  input  logic [2:0]                  I_CCValue,
  input  logic                        I_CCWEn,
  input  logic [VREG_ID_WIDTH-1:0]    I_DestVRegIdx,
  input  logic [VREG_WIDTH-1:0]       I_VecDestValue,
  input  logic                        I_VRegWEn,
  output logic                        O_WBStall,
  output logic                        O_RegWEn,
  output logic [3:0]                  O_DestRegIdx,
  output logic [REG_WIDTH-1:0]        O_DestValue,
  output logic                        O_CCWEn,
  output logic [2:0]                  O_CCValue,
  output logic                        O_VRegWEn,
  output logic [VREG_ID_WIDTH-1:0]    O_DestVRegIdx,
  output logic [LANE_IDX_W-1:0]       O_VRegLaneIdx,
  output logic [LANE_WIDTH-1:0]       O_VRegLaneValue,
  output logic [RETIRE_CNT_WIDTH-1:0] O_RetireCount,
  output logic                        O_FwdValid,
  output logic [3:0]                  O_FwdRegIdx,
  output logic [REG_WIDTH-1:0]        O_FwdValue
);

  logic                        accept_c;
  logic                        unused_opcode_c;

  logic                        reg_wen_q, reg_wen_d;
  logic [3:0]                  dest_idx_q, dest_idx_d;
  logic [REG_WIDTH-1:0]        dest_val_q, dest_val_d;
  logic                        cc_wen_q, cc_wen_d;
  logic [2:0]                  cc_val_q, cc_val_d;
  logic [RETIRE_CNT_WIDTH-1:0] retire_cnt_q, retire_cnt_d;

  // Opcode is carried for debug only.
  assign unused_opcode_c = ^I_Opcode;

  // Inputs offered while stalled are held upstream and taken later.
  assign accept_c = I_LOCK & I_MEM_Valid & ~O_WBStall;

  // Scalar/CC commit and retire count; enables are single-edge pulses.
  always_comb begin
    reg_wen_d    = 1'b0;
    cc_wen_d     = 1'b0;
    dest_idx_d   = dest_idx_q;
    dest_val_d   = dest_val_q;
    cc_val_d     = cc_val_q;
    retire_cnt_d = retire_cnt_q;
    if (accept_c) begin
      reg_wen_d    = I_RegWEn;
      dest_idx_d   = I_DestRegIdx;
      dest_val_d   = I_DestValue;
      cc_wen_d     = I_CCWEn;
      cc_val_d     = I_CCValue;
      retire_cnt_d = retire_cnt_q + RETIRE_CNT_WIDTH'(1);
    end
  end

  always_ff @(negedge I_CLOCK) begin
    if (I_RESET) begin
      reg_wen_q    <= 1'b0;
      dest_idx_q   <= '0;
      dest_val_q   <= '0;
      cc_wen_q     <= 1'b0;
      cc_val_q     <= '0;
      retire_cnt_q <= '0;
    end else begin
      reg_wen_q    <= reg_wen_d;
      dest_idx_q   <= dest_idx_d;
      dest_val_q   <= dest_val_d;
      cc_wen_q     <= cc_wen_d;
      cc_val_q     <= cc_val_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign O_RegWEn      = reg_wen_q;
  assign O_DestRegIdx  = dest_idx_q;
  assign O_DestValue   = dest_val_q;
  assign O_CCWEn       = cc_wen_q;
  assign O_CCValue     = cc_val_q;
  assign O_RetireCount = retire_cnt_q;

  vreg_lane_serializer #(
    .LANES      (LANES),
    .LANE_WIDTH (LANE_WIDTH),
    .VID_W      (VREG_ID_WIDTH)
  ) u_vreg_lane_serializer (
    .clk_i      (I_CLOCK),
    .rst_i      (I_RESET),
    .start_i    (accept_c & I_VRegWEn),
    .vec_i      (I_VecDestValue),
    .vidx_i     (I_DestVRegIdx),
    .stall_o    (O_WBStall),
    .vwen_o     (O_VRegWEn),
    .vidx_o     (O_DestVRegIdx),
    .lane_idx_o (O_VRegLaneIdx),
    .lane_val_o (O_VRegLaneValue)
  );

`ifdef WB_BYPASS_EN
  // Decode sees the scalar result one cycle ahead of the RF write.
  assign O_FwdValid  = I_LOCK & I_MEM_Valid & I_RegWEn & ~O_WBStall & ~I_RESET;
  assign O_FwdRegIdx = I_DestRegIdx;
  assign O_FwdValue  = I_DestValue;
`else
  assign O_FwdValid  = 1'b0;
  assign O_FwdRegIdx = '0;
  assign O_FwdValue  = '0;
`endif

endmodule : writeback_stage

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage. Inputs change 1 time
// unit after each negedge; outputs are sampled there as well.
module tb_writeback_stage;

  logic        I_CLOCK;
  logic        I_RESET;
  logic        I_LOCK;
  logic        I_MEM_Valid;
  logic [7:0]  I_Opcode;
  logic [3:0]  I_DestRegIdx;
  logic [15:0] I_DestValue;
  logic        I_RegWEn;
  logic [2:0]  I_CCValue;
  logic        I_CCWEn;
  logic [5:0]  I_DestVRegIdx;
  logic [63:0] I_VecDestValue;
  logic        I_VRegWEn;
  logic        O_WBStall;
  logic        O_RegWEn;
  logic [3:0]  O_DestRegIdx;
  logic [15:0] O_DestValue;
  logic        O_CCWEn;
  logic [2:0]  O_CCValue;
  logic        O_VRegWEn;
  logic [5:0]  O_DestVRegIdx;
  logic [1:0]  O_VRegLaneIdx;
  logic [15:0] O_VRegLaneValue;
  logic [15:0] O_RetireCount;
  logic        O_FwdValid;
  logic [3:0]  O_FwdRegIdx;
  logic [15:0] O_FwdValue;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  writeback_stage dut (
    .I_CLOCK         (I_CLOCK),
    .I_RESET         (I_RESET),
    .I_LOCK          (I_LOCK),
    .I_MEM_Valid     (I_MEM_Valid),
    .I_Opcode        (I_Opcode),
    .I_DestRegIdx    (I_DestRegIdx),
    .I_DestValue     (I_DestValue),
    .I_RegWEn        (I_RegWEn),
    .I_CCValue       (I_CCValue),
    .I_CCWEn         (I_CCWEn),
    .I_DestVRegIdx   (I_DestVRegIdx),
    .I_VecDestValue  (I_VecDestValue),
    .I_VRegWEn       (I_VRegWEn),
    .O_WBStall       (O_WBStall),
    .O_RegWEn        (O_RegWEn),
    .O_DestRegIdx    (O_DestRegIdx),
    .O_DestValue     (O_DestValue),
    .O_CCWEn         (O_CCWEn),
    .O_CCValue       (O_CCValue),
    .O_VRegWEn       (O_VRegWEn),
    .O_DestVRegIdx   (O_DestVRegIdx),
    .O_VRegLaneIdx   (O_VRegLaneIdx),
    .O_VRegLaneValue (O_VRegLaneValue),
    .O_RetireCount   (O_RetireCount),
    .O_FwdValid      (O_FwdValid),
    .O_FwdRegIdx     (O_FwdRegIdx),
    .O_FwdValue      (O_FwdValue)
  );

  initial I_CLOCK = 1'b0;
  always #5 I_CLOCK = ~I_CLOCK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge I_CLOCK);
    #1;
  endtask

  task automatic drive(input logic lock, input logic valid, input logic rwen,
                       input logic [3:0] idx, input logic [15:0] val,
                       input logic ccwen, input logic [2:0] cc,
                       input logic vwen, input logic [5:0] vidx,
                       input logic [63:0] vec);
    I_LOCK         = lock;
    I_MEM_Valid    = valid;
    I_RegWEn       = rwen;
    I_DestRegIdx   = idx;
    I_DestValue    = val;
    I_CCWEn        = ccwen;
    I_CCValue      = cc;
    I_VRegWEn      = vwen;
    I_DestVRegIdx  = vidx;
    I_VecDestValue = vec;
    I_Opcode       = 8'h5A;
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 3'd0, 1'b0, 6'd0, 64'h0);
  endtask

  // Checks the lane port after one edge of a vector write.
  task automatic chk_lane(input string tag, input logic [1:0] lane,
                          input logic [15:0] val, input logic [5:0] vidx,
                          input logic stall);
    chk({tag, "_vwen"},  64'(O_VRegWEn), 64'(1'b1));
    chk({tag, "_lane"},  64'(O_VRegLaneIdx), 64'(lane));
    chk({tag, "_val"},   64'(O_VRegLaneValue), 64'(val));
    chk({tag, "_vidx"},  64'(O_DestVRegIdx), 64'(vidx));
    chk({tag, "_stall"}, 64'(O_WBStall), 64'(stall));
  endtask

  logic [15:0] lane_vals [4];
  logic [15:0] lane_vals2 [4];

  initial begin
    lane_vals  = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    lane_vals2 = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};

    // Reset state
    I_RESET = 1'b1;
    idle();
    tick();
    tick();
    chk("rst_stall", 64'(O_WBStall), 64'(0));
    chk("rst_rwen",  64'(O_RegWEn), 64'(0));
    chk("rst_ccwen", 64'(O_CCWEn), 64'(0));
    chk("rst_vwen",  64'(O_VRegWEn), 64'(0));
    chk("rst_cnt",   64'(O_RetireCount), 64'(0));
    chk("rst_val",   64'(O_DestValue), 64'(0));
    I_RESET = 1'b0;

    // Scalar + CC commit
    drive(1'b1, 1'b1, 1'b1, 4'd5, 16'h00AB, 1'b1, 3'b010, 1'b0, 6'd0, 64'h0);
`ifndef WB_BYPASS_EN
    #1;
    chk("nobyp_valid", 64'(O_FwdValid), 64'(0));
    chk("nobyp_idx",   64'(O_FwdRegIdx), 64'(0));
    chk("nobyp_val",   64'(O_FwdValue), 64'(0));
`endif
    tick();
    chk("sc_rwen",  64'(O_RegWEn), 64'(1));
    chk("sc_idx",   64'(O_DestRegIdx), 64'(5));
    chk("sc_val",   64'(O_DestValue), 64'(16'h00AB));
    chk("sc_ccwen", 64'(O_CCWEn), 64'(1));
    chk("sc_cc",    64'(O_CCValue), 64'(3'b010));
    chk("sc_vwen",  64'(O_VRegWEn), 64'(0));
    chk("sc_cnt",   64'(O_RetireCount), 64'(1));
    idle();
    tick();
    chk("sc_pulse_rwen",  64'(O_RegWEn), 64'(0));
    chk("sc_pulse_ccwen", 64'(O_CCWEn), 64'(0));
    chk("sc_hold_val",    64'(O_DestValue), 64'(16'h00AB));
    chk("sc_hold_cnt",    64'(O_RetireCount), 64'(1));

    // Vector serialisation with a scalar instruction held behind it
    drive(1'b1, 1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 3'd0, 1'b1, 6'd7, 64'h4444_3333_2222_1111);
    tick();
    chk_lane("v0", 2'd0, 16'h1111, 6'd7, 1'b1);
    chk("v0_cnt", 64'(O_RetireCount), 64'(2));
    drive(1'b1, 1'b1, 1'b1, 4'd9, 16'h0BEE, 1'b0, 3'd0, 1'b0, 6'd0, 64'h0);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk_lane($sformatf("v%0d", k), 2'(k), lane_vals[k], 6'd7, (k < 3));
      chk($sformatf("v%0d_rwen", k), 64'(O_RegWEn), 64'(0));
      chk($sformatf("v%0d_cnt", k), 64'(O_RetireCount), 64'(2));
    end
    tick();
    chk("held_vwen", 64'(O_VRegWEn), 64'(0));
    chk("held_rwen", 64'(O_RegWEn), 64'(1));
    chk("held_idx",  64'(O_DestRegIdx), 64'(9));
    chk("held_val",  64'(O_DestValue), 64'(16'h0BEE));
    chk("held_cnt",  64'(O_RetireCount), 64'(3));

    // Invalid instruction, then lock low
    drive(1'b1, 1'b0, 1'b1, 4'd3, 16'hDEAD, 1'b1, 3'b111, 1'b1, 6'd1, 64'hFFFF);
    tick();
    chk("inv_rwen",  64'(O_RegWEn), 64'(0));
    chk("inv_ccwen", 64'(O_CCWEn), 64'(0));
    chk("inv_vwen",  64'(O_VRegWEn), 64'(0));
    chk("inv_cnt",   64'(O_RetireCount), 64'(3));
    drive(1'b0, 1'b1, 1'b1, 4'd3, 16'hDEAD, 1'b1, 3'b111, 1'b1, 6'd1, 64'hFFFF);
    tick();
    chk("lock_rwen",  64'(O_RegWEn), 64'(0));
    chk("lock_ccwen", 64'(O_CCWEn), 64'(0));
    chk("lock_vwen",  64'(O_VRegWEn), 64'(0));
    chk("lock_cnt",   64'(O_RetireCount), 64'(3));

    // Lock drops during a vector write: all lanes still land
    drive(1'b1, 1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 3'd0, 1'b1, 6'd3, 64'hDDDD_CCCC_BBBB_AAAA);
    tick();
    chk_lane("lk0", 2'd0, 16'hAAAA, 6'd3, 1'b1);
    I_LOCK = 1'b0;
    for (int k = 1; k < 4; k++) begin
      tick();
      chk_lane($sformatf("lk%0d", k), 2'(k), lane_vals2[k], 6'd3, (k < 3));
    end
    tick();
    chk("lk_done_vwen", 64'(O_VRegWEn), 64'(0));
    chk("lk_done_cnt",  64'(O_RetireCount), 64'(4));

    // Reset in the middle of a vector write
    drive(1'b1, 1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 3'd0, 1'b1, 6'd7, 64'h4444_3333_2222_1111);
    tick();
    chk_lane("rm0", 2'd0, 16'h1111, 6'd7, 1'b1);
    tick();
    chk_lane("rm1", 2'd1, 16'h2222, 6'd7, 1'b1);
    I_RESET = 1'b1;
    tick();
    chk("rm_vwen",  64'(O_VRegWEn), 64'(0));
    chk("rm_lane",  64'(O_VRegLaneValue), 64'(0));
    chk("rm_vidx",  64'(O_DestVRegIdx), 64'(0));
    chk("rm_stall", 64'(O_WBStall), 64'(0));
    chk("rm_cnt",   64'(O_RetireCount), 64'(0));
    I_RESET = 1'b0;
    idle();
    for (int k = 0; k < 2; k++) begin
      tick();
      chk($sformatf("rm_after%0d_vwen", k), 64'(O_VRegWEn), 64'(0));
      chk($sformatf("rm_after%0d_stall", k), 64'(O_WBStall), 64'(0));
    end

`ifdef WB_BYPASS_EN
    // Bypass visible before the RF write, suppressed while stalled
    drive(1'b1, 1'b1, 1'b1, 4'd2, 16'h1234, 1'b0, 3'd0, 1'b0, 6'd0, 64'h0);
    #1;
    chk("byp_valid", 64'(O_FwdValid), 64'(1));
    chk("byp_idx",   64'(O_FwdRegIdx), 64'(2));
    chk("byp_val",   64'(O_FwdValue), 64'(16'h1234));
    tick();
    chk("byp_rwen",  64'(O_RegWEn), 64'(1));
    drive(1'b1, 1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 3'd0, 1'b1, 6'd4, 64'h1);
    tick();
    drive(1'b1, 1'b1, 1'b1, 4'd2, 16'h1234, 1'b0, 3'd0, 1'b0, 6'd0, 64'h0);
    #1;
    chk("byp_stall_valid", 64'(O_FwdValid), 64'(0));
    repeat (3) tick();
    chk("byp_resume_valid", 64'(O_FwdValid), 64'(1));
    idle();
    tick();
`endif

    // Counter wrap: 65535 accepts reach all-ones, one more wraps to 0
    I_RESET = 1'b1;
    tick();
    I_RESET = 1'b0;
    chk("wrap_start", 64'(O_RetireCount), 64'(0));
    drive(1'b1, 1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 3'd0, 1'b0, 6'd0, 64'h0);
    repeat (65535) tick();
    chk("wrap_max", 64'(O_RetireCount), 64'(16'hFFFF));
    tick();
    chk("wrap_zero", 64'(O_RetireCount), 64'(0));
    idle();
    tick();
    chk("wrap_hold", 64'(O_RetireCount), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_writeback_stage
